// File: rtl/rr_lane_arbiter_2x1.sv
// Two-lane buffered round-robin arbiter feeding a registered 2:1 mux stage.
// Each lane has a small FIFO. A registered output stage carries the granted word and its lane code.

module rr_lane_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [DATA_WIDTH-1:0]   i_data,
    output logic                    o_ready,
    input  logic                    i_pop,
    output logic [DATA_WIDTH-1:0]   o_head,
    output logic                    o_nempty,
    output logic [$clog2(DEPTH):0]  o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] r_mem;
    logic [AW-1:0]                    r_wptr;
    logic [AW-1:0]                    r_rptr;
    logic [AW:0]                      r_count;
    logic                             w_push;

    // Ready depends on occupancy only: a full FIFO refuses even when it pops in the same cycle.
    assign o_ready  = !reset && (r_count < (AW+1)'(DEPTH));
    assign w_push   = i_valid && o_ready;
    assign o_head   = r_mem[r_rptr];
    assign o_nempty = (r_count != '0);
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= i_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (i_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module rr_lane_arbiter_2x1 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   A_in,
    input  logic                    A_valid,
    output logic                    A_ready,
    input  logic [DATA_WIDTH-1:0]   B_in,
    input  logic                    B_valid,
    output logic                    B_ready,
    output logic [DATA_WIDTH-1:0]   Y_out,
    output logic                    Select_out,
    output logic                    Y_valid,
    input  logic                    Y_ready,
    output logic [$clog2(DEPTH):0]  A_count,
    output logic [$clog2(DEPTH):0]  B_count
);
    localparam int AW = $clog2(DEPTH);

    logic [1:0][DATA_WIDTH-1:0] w_in;
    logic [1:0][DATA_WIDTH-1:0] w_head;
    logic [1:0][AW:0]           w_count;
    logic [1:0]                 w_valid;
    logic [1:0]                 w_ready;
    logic [1:0]                 w_pop;
    logic [1:0]                 w_nempty;
    logic                       w_load;
    logic                       w_gnt_vld;
    logic                       w_gnt_lane;

    logic [DATA_WIDTH-1:0]      r_y;
    logic                       r_sel;
    logic                       r_y_valid;
    logic                       r_last;

    assign w_in    = {B_in, A_in};
    assign w_valid = {B_valid, A_valid};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        rr_lane_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .i_valid  (w_valid[g]),
            .i_data   (w_in[g]),
            .o_ready  (w_ready[g]),
            .i_pop    (w_pop[g]),
            .o_head   (w_head[g]),
            .o_nempty (w_nempty[g]),
            .o_count  (w_count[g])
        );
    end

    // Tie goes to the lane that did not win last; a lone non-empty lane always wins.
    always_comb begin
        w_load     = !r_y_valid || Y_ready;
        w_gnt_vld  = |w_nempty;
        w_gnt_lane = 1'b0;
        w_pop      = '0;
        if (&w_nempty)       w_gnt_lane = ~r_last;
        else if (w_nempty[0]) w_gnt_lane = 1'b0;
        else                  w_gnt_lane = 1'b1;
        if (w_load && w_gnt_vld) w_pop[w_gnt_lane] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y       <= '0;
            r_sel     <= 1'b0;
            r_y_valid <= 1'b0;
            r_last    <= 1'b1;
        end else if (w_load) begin
            if (w_gnt_vld) begin
                r_y       <= w_head[w_gnt_lane];
                r_sel     <= w_gnt_lane;
                r_y_valid <= 1'b1;
                r_last    <= w_gnt_lane;
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign A_ready    = w_ready[0];
    assign B_ready    = w_ready[1];
    assign A_count    = w_count[0];
    assign B_count    = w_count[1];
    assign Y_out      = r_y;
    assign Select_out = r_sel;
    assign Y_valid    = r_y_valid;
endmodule

// File: tb/tb_rr_lane_arbiter_2x1.sv
// Directed and randomized checks of rr_lane_arbiter_2x1 against a queue-based reference model.

module tb_rr_lane_arbiter_2x1;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] A_in = '0, B_in = '0;
    logic          A_valid = 1'b0, B_valid = 1'b0, Y_ready = 1'b0;
    logic          A_ready, B_ready, Select_out, Y_valid;
    logic [DW-1:0] Y_out;
    logic [2:0]    A_count, B_count;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] qa[$], qb[$], got[$];
    logic          m_yv, m_sel, m_last;
    logic [DW-1:0] m_y;

    rr_lane_arbiter_2x1 #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .A_in(A_in), .A_valid(A_valid), .A_ready(A_ready),
        .B_in(B_in), .B_valid(B_valid), .B_ready(B_ready),
        .Y_out(Y_out), .Select_out(Select_out), .Y_valid(Y_valid), .Y_ready(Y_ready),
        .A_count(A_count), .B_count(B_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        qa.delete(); qb.delete(); got.delete();
        m_yv = 1'b0; m_y = '0; m_sel = 1'b0; m_last = 1'b1;
    endtask

    // One clock edge: model the edge from the pre-edge state, then compare just after it.
    task automatic tick();
        bit pa, pb;
        logic [DW-1:0] da, db;
        int g;
        chk("a_ready", A_ready, qa.size() < DEPTH);
        chk("b_ready", B_ready, qb.size() < DEPTH);
        if (Y_valid && Y_ready) got.push_back(Y_out);
        pa = A_valid && (qa.size() < DEPTH); da = A_in;
        pb = B_valid && (qb.size() < DEPTH); db = B_in;
        if (!m_yv || Y_ready) begin
            g = -1;
            if (qa.size() > 0 && qb.size() > 0) g = m_last ? 0 : 1;
            else if (qa.size() > 0) g = 0;
            else if (qb.size() > 0) g = 1;
            if (g == 0)      begin m_y = qa.pop_front(); m_sel = 1'b0; m_yv = 1'b1; m_last = 1'b0; end
            else if (g == 1) begin m_y = qb.pop_front(); m_sel = 1'b1; m_yv = 1'b1; m_last = 1'b1; end
            else m_yv = 1'b0;
        end
        if (pa) qa.push_back(da);
        if (pb) qb.push_back(db);
        @(posedge clk); #1;
        chk("y_valid", Y_valid, m_yv);
        chk("y_out",   Y_out,   m_y);
        chk("sel",     Select_out, m_sel);
        chk("a_count", A_count, qa.size());
        chk("b_count", B_count, qb.size());
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; A_valid = 0; B_valid = 0;
        mreset();
        @(negedge clk); reset = 1'b0; #1;
    endtask

    task automatic drain(input int n);
        A_valid = 0; B_valid = 0; Y_ready = 1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        mreset();
        #1;
        chk("rst_a_ready", A_ready, 0);
        chk("rst_y_valid", Y_valid, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("rel_a_ready", A_ready, 1);

        // single word
        A_valid = 1; A_in = 8'h3C; Y_ready = 1;
        tick();
        A_valid = 0;
        tick();
        chk("single_v", Y_valid, 1); chk("single_y", Y_out, 8'h3C); chk("single_s", Select_out, 0);
        tick();
        chk("single_done", Y_valid, 0);

        // round-robin from a fresh reset
        do_reset();
        Y_ready = 0;
        A_valid = 1; B_valid = 1; A_in = 8'h11; B_in = 8'h21; tick();
        A_in = 8'h12; B_in = 8'h22; tick();
        A_valid = 0; B_valid = 0;
        chk("rr_first", Y_out, 8'h11); chk("rr_first_s", Select_out, 0);
        Y_ready = 1;
        begin
            logic [DW-1:0] ey[3];
            logic          es[3];
            ey = '{8'h21, 8'h12, 8'h22};
            es = '{1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("rr_y", Y_out, ey[i]); chk("rr_s", Select_out, es[i]);
            end
        end
        drain(2);

        // back-pressure until A is full, then release
        do_reset();
        Y_ready = 0; A_valid = 1;
        for (int w = 1; w <= 5; w++) begin A_in = DW'(w); tick(); end
        A_in = 8'h06;
        chk("bp_full_rdy", A_ready, 0); chk("bp_cnt", A_count, 4); chk("bp_hold", Y_out, 8'h01);
        tick();
        chk("bp_hold2", Y_out, 8'h01);
        Y_ready = 1;
        for (int i = 0; i < 10 && A_valid; i++) begin
            if (A_ready) begin tick(); A_valid = 0; end else tick();
        end
        drain(8);
        chk("bp_len", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) chk("bp_ord", got[i], i + 1);

        // wrap-around single-lane stream
        got.delete();
        A_valid = 1; Y_ready = 1;
        for (int w = 0; w < 10; w++) begin
            A_in = DW'(w); tick();
            chk("wrap_cnt", A_count <= 1, 1);
        end
        drain(4);
        chk("wrap_len", got.size(), 10);
        for (int i = 0; i < got.size() && i < 10; i++) chk("wrap_ord", got[i], i);

        // B streams, A slips one word in
        got.delete();
        B_valid = 1; Y_ready = 1;
        for (int i = 0; i < 12; i++) begin
            B_in = 8'hB0 + DW'(i);
            A_valid = (i == 4); A_in = 8'h55;
            tick();
        end
        drain(8);
        begin
            int n55 = 0;
            foreach (got[i]) if (got[i] == 8'h55) n55++;
            chk("starve_seen", n55, 1);
            chk("starve_len", got.size(), 13);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            A_valid = $urandom_range(0, 1); A_in = DW'($urandom);
            B_valid = $urandom_range(0, 1); B_in = DW'($urandom);
            Y_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // reset mid-cycle with data buffered
        Y_ready = 0; A_valid = 1; B_valid = 1;
        for (int i = 0; i < 3; i++) begin A_in = DW'(i); B_in = DW'(i + 8'h40); tick(); end
        A_valid = 0; B_valid = 0;
        #3 reset = 1'b1; #1;
        mreset();
        chk("mid_y_valid", Y_valid, 0); chk("mid_y_out", Y_out, 0); chk("mid_sel", Select_out, 0);
        chk("mid_a_cnt", A_count, 0);   chk("mid_b_cnt", B_count, 0);
        chk("mid_a_rdy", A_ready, 0);   chk("mid_b_rdy", B_ready, 0);
        @(posedge clk); #1;
        chk("mid_hold_rdy", B_ready, 0);
        @(negedge clk); reset = 1'b0; #1;
        chk("mid_rel_a", A_ready, 1); chk("mid_rel_b", B_ready, 1);
        drain(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_lane_arbiter_2x1.md
Name: rr_lane_arbiter_2x1

Overview:
- Two-lane buffered round-robin arbiter that sits directly upstream of the registered 2:1 mux stage.
- Each lane (A, B) has its own small FIFO. The block picks one lane per transfer and presents the chosen word together with the select code the mux stage consumes (Select 0 = A, 1 = B).
- It decouples bursty lane producers from the mux and downstream consumer using valid/ready handshakes on every interface.

Parameters:
- DATA_WIDTH, 8, width of each lane word and of Y_out.
- DEPTH, 4, entries per lane FIFO; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- A_in  input  DATA_WIDTH  lane A data.
- A_valid  input  1  lane A word present.
- A_ready  output  1  lane A FIFO can accept.
- B_in  input  DATA_WIDTH  lane B data.
- B_valid  input  1  lane B word present.
- B_ready  output  1  lane B FIFO can accept.
- Y_out  output  DATA_WIDTH  granted word, registered.
- Select_out  output  1  lane of Y_out: 0 = A, 1 = B; registered.
- Y_valid  output  1  Y_out/Select_out valid.
- Y_ready  input  1  consumer accepts Y_out.
- A_count  output  clog2(DEPTH)+1  lane A FIFO occupancy.
- B_count  output  clog2(DEPTH)+1  lane B FIFO occupancy.

Behaviour:
- Reset (async, active-high): FIFO pointers and counts cleared, FIFO contents discarded. Y_out=0, Select_out=0, Y_valid=0, last_grant=1 (so the first tie goes to A). A_ready and B_ready forced 0 while reset is high.
- Reset mid-operation: everything above takes effect immediately, with no waiting for a clock edge. In-flight words are lost. A word presented on the deasserting edge is not accepted.
- Push: a lane push occurs on the clk edge where X_valid && X_ready.
- Ready: X_ready = !reset && (X_count < DEPTH), combinational from count only. There is no push-on-full bypass, even when a pop happens in the same cycle.
- Pointers: write and read pointers wrap modulo DEPTH. Count increments on push, decrements on pop, and is unchanged on simultaneous push+pop.
- Output stage load condition: (!Y_valid || Y_ready). On each edge where this holds:
  - Both FIFOs non-empty: grant the lane != last_grant.
  - Only one FIFO non-empty: grant that lane.
  - Both empty: Y_valid <= 0; Y_out and Select_out hold their old values.
  - On grant: Y_out <= head of the granted FIFO, Select_out <= granted lane, Y_valid <= 1. Pop that FIFO; last_grant <= granted lane.
- Arbitration sees FIFO state before the edge. A word pushed at edge n into an empty FIFO can be granted at edge n+1 at the earliest, so minimum latency is 2 edges from input valid to Y_valid.
- Back-pressure: while Y_valid && !Y_ready, Y_out, Select_out and Y_valid hold stable and no pop occurs.
- Sustained throughput: 1 word per cycle with Y_ready held high. Lanes alternate strictly while both are non-empty.
- Per-lane order is preserved (FIFO). There is no ordering guarantee between lanes beyond round-robin.
- Capacity: one lane can hold DEPTH words in its FIFO plus 1 in the output stage.

Test Plan:
- Reset: assert reset mid-cycle with data buffered -> Y_valid=0, Y_out=0x00, Select_out=0, A_count=B_count=0 immediately; A_ready=B_ready=0 while reset is high, 1 after release.
- Single word: push A_in=0x3C at edge n, Y_ready=1 -> Y_valid=1, Y_out=0x3C, Select_out=0 after edge n+1. Y_valid=0 one edge after consumption.
- Round-robin: preload A={0x11,0x12}, B={0x21,0x22} with Y_ready=0, then Y_ready=1 -> Y_out sequence 0x11,0x21,0x12,0x22 with Select_out 0,1,0,1.
- Back-pressure/full: Y_ready=0, A_valid=1 with words 0x01..0x06 -> first 5 accepted (0x01 in output stage, A_count=4), A_ready=0 for 0x06. Y_out holds 0x01. Release Y_ready -> 0x01..0x06 emerge in order.
- Wrap-around: continuous A stream 0x00..0x09 with Y_ready=1 and B idle -> Y_out 0x00..0x09 in order, one per cycle, Select_out=0 throughout, A_count never exceeds 1.
- Single-lane starvation check: B stream continuous, A gets one word 0x55 -> 0x55 granted at the next load edge after it lands in the FIFO, then B resumes.
